instr_fetch_assembler: RTL and testbench

// - Fetch stage directly downstream of programCounter. Accepts an 8-bit instruction address, reads

---
 rtl/fetch_pkg.sv | 33 +++
 rtl/byte_assembler.sv | 63 ++++++
 rtl/instr_fetch_assembler.sv | 156 +++++++++++++++
 tb/tb_instr_fetch_assembler.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch path.
// - fetch_state_t : fetch FSM states (IDLE, FETCH, HOLD).
// - INSTR_W       : default instruction width, also used by decode.
// - cnt_w()       : width of a counter that spans 0..bytes_per_instr.
// - byte_lane()   : which byte lane of the instruction a fetched byte lands in.
package fetch_pkg;

  localparam int FETCH_BYTES = 4;
  localparam int INSTR_W     = 8 * FETCH_BYTES;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  function automatic int cnt_w(input int bytes_per_instr);
    return $clog2(bytes_per_instr + 1);
  endfunction

  localparam int CNT_W = cnt_w(FETCH_BYTES);

  // Byte idx is the offset from the base address; big-endian reverses lanes.
  function automatic int byte_lane(input int idx, input int bytes_per_instr,
                                   input bit big_endian);
    if (big_endian) begin
      return bytes_per_instr - 1 - idx;
    end else begin
      return idx;
    end
  endfunction

endpackage

// File: rtl/byte_assembler.sv
// Collects the bytes of one instruction into an assembly register and
// publishes the full word only when the last byte arrives.
// Ports:
//   clock, reset_n : clock and synchronous active-low reset
//   clear          : discard any partially assembled bytes
//   capture        : data holds the byte at offset idx this cycle
//   idx            : byte offset from the instruction base (0 = base)
//   data           : byte from memory
//   instr          : last complete instruction (never a partial value)
//   done           : this capture completes the instruction
module byte_assembler
  import fetch_pkg::*;
#(
  parameter int BYTES_PER_INSTR = 4,
  parameter bit BIG_ENDIAN      = 1'b0,
  parameter int IDX_W           = 3
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         clear,
  input  logic                         capture,
  input  logic [IDX_W-1:0]             idx,
  input  logic [7:0]                   data,
  output logic [8*BYTES_PER_INSTR-1:0] instr,
  output logic                         done
);

  localparam int DATA_W = 8 * BYTES_PER_INSTR;

  logic [DATA_W-1:0] assembly;
  logic [DATA_W-1:0] assembly_next;

  // The final byte of an instruction completes the load.
  always_comb begin
    done = capture && (idx == IDX_W'(BYTES_PER_INSTR - 1));
  end

  // Merge the incoming byte into its lane of the assembly word.
  always_comb begin
    assembly_next = assembly;
    if (capture) begin
      assembly_next[8*byte_lane(int'(idx), BYTES_PER_INSTR, BIG_ENDIAN) +: 8] = data;
    end else begin
      assembly_next = assembly;
    end
  end

  // Assembly register; instr is refreshed only with the complete word.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      assembly <= '0;
      instr    <= '0;
    end else if (clear) begin
      assembly <= '0;
    end else begin
      assembly <= assembly_next;
      if (done) begin
        instr <= assembly_next;
      end
    end
  end

endmodule

// File: rtl/instr_fetch_assembler.sv
// Fetch stage: takes an instruction address from the program counter, reads
// BYTES_PER_INSTR consecutive bytes from a 1-cycle synchronous byte memory,
// and hands the assembled instruction to decode over valid/ready.
// Ports:
//   clock, reset_n          : clock and synchronous active-low reset
//   pc_addr, pc_valid       : next instruction address from the PC
//   pc_ready                : address accepted this cycle
//   flush                   : abandon the in-flight fetch / drop held instr
//   mem_en, mem_addr        : byte read request (registered)
//   mem_rdata               : read data, one cycle after the request
//   instr, instr_pc         : assembled instruction and its base address
//   instr_valid, instr_ready: handshake towards decode
module instr_fetch_assembler
  import fetch_pkg::*;
#(
  parameter int ADDR_W          = 8,
  parameter int BYTES_PER_INSTR = 4,
  parameter bit BIG_ENDIAN      = 1'b0
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [ADDR_W-1:0]            pc_addr,
  input  logic                         pc_valid,
  output logic                         pc_ready,
  input  logic                         flush,
  output logic                         mem_en,
  output logic [ADDR_W-1:0]            mem_addr,
  input  logic [7:0]                   mem_rdata,
  output logic [8*BYTES_PER_INSTR-1:0] instr,
  output logic [ADDR_W-1:0]            instr_pc,
  output logic                         instr_valid,
  input  logic                         instr_ready
);

  localparam int CNT_BITS = cnt_w(BYTES_PER_INSTR);
  localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(BYTES_PER_INSTR);

  fetch_state_t        state;
  fetch_state_t        state_next;
  logic [CNT_BITS-1:0] cnt;
  logic [CNT_BITS-1:0] cnt_next;
  logic [CNT_BITS-1:0] byte_idx;
  logic [ADDR_W-1:0]   base;
  logic [ADDR_W-1:0]   base_next;
  logic                accept;
  logic                capture;
  logic                load_done;
  logic                issue_next;

  // A new address is taken when idle, or when decode frees the held slot.
  always_comb begin
    pc_ready = 1'b0;
    if (flush) begin
      pc_ready = 1'b0;
    end else begin
      case (state)
        IDLE:    pc_ready = 1'b1;
        FETCH:   pc_ready = 1'b0;
        HOLD:    pc_ready = instr_ready;
        default: pc_ready = 1'b0;
      endcase
    end
  end

  // Data seen in cycle cnt belongs to the request issued in cycle cnt-1.
  always_comb begin
    accept   = pc_valid && pc_ready;
    byte_idx = cnt - CNT_BITS'(1);
    capture  = (state == FETCH) && (cnt != '0) && !flush;
  end

  // Next-state logic; flush has the final word over accept and consume.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    base_next  = base;
    case (state)
      IDLE: begin
        state_next = IDLE;
      end
      FETCH: begin
        if (load_done) begin
          state_next = HOLD;
        end else begin
          cnt_next = cnt + CNT_BITS'(1);
        end
      end
      HOLD: begin
        if (instr_ready) begin
          state_next = IDLE;
        end else begin
          state_next = HOLD;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (accept) begin
      state_next = FETCH;
      cnt_next   = '0;
      base_next  = pc_addr;
    end else begin
      base_next = base;
    end
    if (flush) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      cnt_next = cnt_next;
    end
    issue_next = (state_next == FETCH) && (cnt_next < LAST_CNT);
  end

  // FSM registers plus registered memory request and output qualifiers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      base        <= '0;
      mem_en      <= 1'b0;
      mem_addr    <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      base        <= base_next;
      mem_en      <= issue_next;
      instr_valid <= (state_next == HOLD);
      if (issue_next) begin
        // Addresses wrap naturally at 2^ADDR_W.
        mem_addr <= base_next + ADDR_W'(cnt_next);
      end
      if (load_done) begin
        instr_pc <= base;
      end
    end
  end

  byte_assembler #(
    .BYTES_PER_INSTR(BYTES_PER_INSTR),
    .BIG_ENDIAN     (BIG_ENDIAN),
    .IDX_W          (CNT_BITS)
  ) u_byte_assembler (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (flush),
    .capture(capture),
    .idx    (byte_idx),
    .data   (mem_rdata),
    .instr  (instr),
    .done   (load_done)
  );

endmodule

// File: tb/tb_instr_fetch_assembler.sv
module tb_instr_fetch_assembler;

  logic        clock = 1'b0;
  logic        reset_n, pc_valid, flush, instr_ready;
  logic [7:0]  pc_addr, mem_rdata;
  logic        pc_ready, mem_en, instr_valid;
  logic [7:0]  mem_addr, instr_pc;
  logic [31:0] instr;
  logic        be_pc_ready, be_mem_en, be_instr_valid;
  logic [7:0]  be_mem_addr, be_instr_pc;
  logic [31:0] be_instr;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int consumed = 0;

  logic [7:0] mem [256];

  typedef struct {
    logic [7:0]  base;
    logic [31:0] le;
    logic [31:0] be;
    int          acc;
  } exp_t;
  exp_t sb[$];

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  instr_fetch_assembler #(.ADDR_W(8), .BYTES_PER_INSTR(4), .BIG_ENDIAN(1'b0)) dut (
    .clock(clock), .reset_n(reset_n), .pc_addr(pc_addr), .pc_valid(pc_valid),
    .pc_ready(pc_ready), .flush(flush), .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready)
  );

  instr_fetch_assembler #(.ADDR_W(8), .BYTES_PER_INSTR(4), .BIG_ENDIAN(1'b1)) dut_be (
    .clock(clock), .reset_n(reset_n), .pc_addr(pc_addr), .pc_valid(pc_valid),
    .pc_ready(be_pc_ready), .flush(flush), .mem_en(be_mem_en), .mem_addr(be_mem_addr),
    .mem_rdata(mem_rdata), .instr(be_instr), .instr_pc(be_instr_pc),
    .instr_valid(be_instr_valid), .instr_ready(instr_ready)
  );

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
  end

  // Synchronous 1-cycle memory; junk on the bus when not reading.
  always @(posedge clock) begin
    if (mem_en === 1'b1) mem_rdata <= mem[mem_addr];
    else mem_rdata <= 8'($urandom);
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference: instruction bytes are mem[(base+i) mod 256] = (base+i) ^ A5.
  function automatic logic [31:0] ref_instr(input logic [7:0] b, input bit big);
    logic [31:0] r;
    logic [7:0]  a;
    logic [7:0]  d;
    r = 32'h0;
    for (int i = 0; i < 4; i++) begin
      a = b + 8'(i);
      d = a ^ 8'hA5;
      if (big) r = r | (32'(d) << (8 * (3 - i)));
      else     r = r | (32'(d) << (8 * i));
    end
    return r;
  endfunction

  // Monitor / scoreboard, sampled on the falling edge.
  always @(negedge clock) begin
    bit         have, fetching, holding;
    int         k;
    logic       exp_ready;
    logic [7:0] ea;
    if (reset_n === 1'b1) begin
      have      = sb.size() > 0;
      k         = have ? (cyc - sb[0].acc) : 0;
      fetching  = have && (k < 5);
      holding   = have && (k >= 5);
      exp_ready = flush ? 1'b0 : (!have ? 1'b1 : (fetching ? 1'b0 : instr_ready));
      check("pc_ready", pc_ready, exp_ready);
      check("be_pc_ready", be_pc_ready, exp_ready);
      check("instr_valid", instr_valid, holding);
      check("be_instr_valid", be_instr_valid, holding);
      if (fetching && k < 4) begin
        ea = sb[0].base + 8'(k);
        check("mem_en_fetch", mem_en, 1'b1);
        check("mem_addr", mem_addr, ea);
      end else begin
        check("mem_en_quiet", mem_en, 1'b0);
      end
      if (holding) begin
        check("instr", instr, sb[0].le);
        check("instr_pc", instr_pc, sb[0].base);
        check("be_instr", be_instr, sb[0].be);
        check("be_instr_pc", be_instr_pc, sb[0].base);
      end
      if (flush) begin
        sb.delete();
      end else begin
        if (holding && instr_ready) begin
          sb.delete(0);
          consumed++;
        end
        if (pc_valid && exp_ready)
          sb.push_back('{pc_addr, ref_instr(pc_addr, 1'b0), ref_instr(pc_addr, 1'b1), cyc + 1});
      end
    end else begin
      sb.delete();
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [7:0] a);
    bit ok;
    ok = 1'b0;
    pc_addr  = a;
    pc_valid = 1'b1;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clock);
      if (pc_ready === 1'b1 && flush === 1'b0) ok = 1'b1;
      @(posedge clock);
      #1;
    end
    pc_valid = 1'b0;
    check("accept_timeout", ok, 1'b1);
  endtask

  task automatic wait_valid();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clock);
      if (instr_valid === 1'b1) ok = 1'b1;
    end
    check("valid_timeout", ok, 1'b1);
  endtask

  initial begin
    logic [7:0] pc;
    int         n;
    int         c0;
    bit         acc;
    reset_n = 1'b0; pc_valid = 1'b0; flush = 1'b0; instr_ready = 1'b0; pc_addr = 8'h00;
    repeat (3) step();
    reset_n = 1'b1;
    step();

    // Reset held for 3 cycles in the middle of a fetch.
    instr_ready = 1'b1;
    issue(8'h40);
    step();
    step();
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clock);
      check("rst_mem_en", mem_en, 1'b0);
      check("rst_mem_addr", mem_addr, 8'h00);
      check("rst_instr", instr, 32'h0);
      check("rst_instr_pc", instr_pc, 8'h00);
      check("rst_instr_valid", instr_valid, 1'b0);
    end
    reset_n = 1'b1;
    step();
    @(negedge clock);
    check("rst_release_pc_ready", pc_ready, 1'b1);
    step();

    // Single fetch at 0x10, then 6 cycles of backpressure.
    instr_ready = 1'b0;
    issue(8'h10);
    wait_valid();
    check("single_le", instr, 32'hB6B7B4B5);
    check("single_be", be_instr, 32'hB5B4B7B6);
    check("single_pc", instr_pc, 8'h10);
    step();
    pc_valid = 1'b1;
    pc_addr  = 8'h14;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check("bp_instr", instr, 32'hB6B7B4B5);
      check("bp_pc_ready", pc_ready, 1'b0);
      check("bp_mem_en", mem_en, 1'b0);
      step();
    end
    instr_ready = 1'b1;
    @(negedge clock);
    check("bp_release_accept", pc_ready, 1'b1);
    step();
    pc_valid = 1'b0;
    wait_valid();
    check("bp_next_pc", instr_pc, 8'h14);
    check("bp_next_instr", instr, 32'hB2B3B0B1);
    step();

    // Address wrap.
    issue(8'hFE);
    wait_valid();
    check("wrap_pc", instr_pc, 8'hFE);
    check("wrap_instr", instr, 32'hA4A55A5B);
    step();

    // Flush at cnt=2 together with pc_valid.
    issue(8'h30);
    step();
    step();
    flush    = 1'b1;
    pc_valid = 1'b1;
    pc_addr  = 8'h50;
    @(negedge clock);
    check("flush_no_accept", pc_ready, 1'b0);
    step();
    flush    = 1'b0;
    pc_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      check("flush_dropped", instr_valid, 1'b0);
      step();
    end
    issue(8'h20);
    wait_valid();
    check("post_flush_instr", instr, 32'h86878485);
    check("post_flush_pc", instr_pc, 8'h20);
    step();

    // Stream of 8 back-to-back fetches.
    c0 = consumed;
    pc = 8'h60;
    n  = 0;
    pc_addr  = pc;
    pc_valid = 1'b1;
    for (int i = 0; i < 100 && n < 8; i++) begin
      @(negedge clock);
      acc = (pc_ready === 1'b1);
      @(posedge clock);
      #1;
      if (acc) begin
        n++;
        pc = pc + 8'd4;
        pc_addr = pc;
        if (n == 8) pc_valid = 1'b0;
      end
    end
    pc_valid = 1'b0;
    repeat (10) step();
    check("stream_accepts", n, 8);
    check("stream_consumed", consumed - c0, 8);

    // Random traffic with flushes and jumps.
    for (int i = 0; i < 500; i++) begin
      pc_valid    = ($urandom_range(0, 3) != 0);
      instr_ready = ($urandom_range(0, 2) != 0);
      flush       = ($urandom_range(0, 15) == 0);
      pc_addr     = pc_valid ? pc : 8'($urandom);
      @(negedge clock);
      if (flush) pc = 8'($urandom);
      else if (pc_valid && pc_ready === 1'b1) pc = pc + 8'd4;
      @(posedge clock);
      #1;
    end
    flush = 1'b0;
    pc_valid = 1'b0;
    instr_ready = 1'b1;
    repeat (10) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
